// File: rtl/zycap_axil_regs.sv
// zycap_axil_regs: AXI4-Lite slave with four 32-bit registers and a reg0 write strobe.
// Revision 1.0
`default_nettype none

module zycap_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg0_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg1_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg2_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg3_o,
  output logic                              reg0_wr_pulse
);

  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [DW-1:0]   slv_reg [4];
  logic            ready_en;
  logic            aw_full;
  logic [AW-1:2]   aw_addr_q;
  logic            w_full;
  logic [DW-1:0]   w_data_q;
  logic [SW-1:0]   w_strb_q;
  logic            bvalid_q;
  logic [1:0]      bresp_q;
  logic            rvalid_q;
  logic [DW-1:0]   rdata_q;
  logic [1:0]      rresp_q;
  logic            pulse_q;

  logic            aw_hs;
  logic            w_hs;
  logic            ar_hs;
  logic            commit;
  logic [AW-1:2]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic [SW-1:0]   wr_strb;
  logic            wr_mapped;
  logic            rd_mapped;
  logic [1:0]      wr_idx;
  logic [1:0]      rd_idx;

  // Ready stays low during reset and rises on the first clock edge afterwards.
  assign S_AXI_AWREADY = ready_en && !aw_full && !bvalid_q;
  assign S_AXI_WREADY  = ready_en && !w_full && !bvalid_q;
  assign S_AXI_ARREADY = ready_en && !rvalid_q;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // A channel counts as present if its holder is full or it handshakes now,
  // which gives one-cycle write latency when both arrive together.
  assign commit    = (aw_full || aw_hs) && (w_full || w_hs);
  assign wr_addr   = aw_full ? aw_addr_q : S_AXI_AWADDR[AW-1:2];
  assign wr_data   = w_full ? w_data_q : S_AXI_WDATA;
  assign wr_strb   = w_full ? w_strb_q : S_AXI_WSTRB;
  assign wr_mapped = (wr_addr[AW-1:4] == '0);
  assign wr_idx    = wr_addr[3:2];
  assign rd_mapped = (S_AXI_ARADDR[AW-1:4] == '0);
  assign rd_idx    = S_AXI_ARADDR[3:2];

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < 4; i++) slv_reg[i] <= '0;
      ready_en  <= 1'b0;
      aw_full   <= 1'b0;
      aw_addr_q <= '0;
      w_full    <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      pulse_q   <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      pulse_q  <= 1'b0;

      if (commit) begin
        aw_full  <= 1'b0;
        w_full   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
        if (wr_mapped) begin
          for (int k = 0; k < SW; k++) begin
            if (wr_strb[k]) slv_reg[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
          end
          pulse_q <= (wr_idx == 2'd0);
        end
      end else begin
        if (aw_hs) begin
          aw_full   <= 1'b1;
          aw_addr_q <= S_AXI_AWADDR[AW-1:2];
        end
        if (w_hs) begin
          w_full   <= 1'b1;
          w_data_q <= S_AXI_WDATA;
          w_strb_q <= S_AXI_WSTRB;
        end
        if (bvalid_q && S_AXI_BREADY) bvalid_q <= 1'b0;
      end

      // Read data is captured from pre-write register contents.
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_mapped ? slv_reg[rd_idx] : '0;
        rresp_q  <= rd_mapped ? RESP_OKAY : RESP_SLVERR;
      end else if (rvalid_q && S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign reg0_o        = slv_reg[0];
  assign reg1_o        = slv_reg[1];
  assign reg2_o        = slv_reg[2];
  assign reg3_o        = slv_reg[3];
  assign reg0_wr_pulse = pulse_q;

  wire unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

`default_nettype wire

// File: tb/tb_zycap_axil_regs.sv
// tb_zycap_axil_regs: directed scoreboard bench for the zycap_axil_regs register slave.
`default_nettype none

module tb_zycap_axil_regs;

  logic        clk;
  logic        rst_n;
  logic [5:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [5:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] reg0_o, reg1_o, reg2_o, reg3_o;
  logic        reg0_wr_pulse;

  zycap_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg0_o(reg0_o), .reg1_o(reg1_o), .reg2_o(reg2_o), .reg3_o(reg3_o),
    .reg0_wr_pulse(reg0_wr_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int pulse_cnt = 0;
  logic [1:0]  bq [$];
  logic [33:0] rq [$];
  logic [31:0] model [4];

  always @(negedge clk) if (reg0_wr_pulse === 1'b1) pulse_cnt++;

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_reg0"}, {32'd0, reg0_o}, {32'd0, model[0]});
    check({tag, "_reg1"}, {32'd0, reg1_o}, {32'd0, model[1]});
    check({tag, "_reg2"}, {32'd0, reg2_o}, {32'd0, model[2]});
    check({tag, "_reg3"}, {32'd0, reg3_o}, {32'd0, model[3]});
  endtask

  // Drives AW and W together, pushes the expected response and updates the model.
  task automatic prep_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic [1:0] er;
    er = (addr[5:4] != 2'b00) ? 2'b10 : 2'b00;
    bq.push_back(er);
    if (er == 2'b00)
      for (int k = 0; k < 4; k++) if (strb[k]) model[addr[3:2]][8*k +: 8] = data[8*k +: 8];
    awaddr = addr; awprot = 3'($urandom_range(7)); awvalid = 1'b1;
    wdata = data; wstrb = strb; wvalid = 1'b1;
  endtask

  task automatic hs_loop();
    int t;
    logic a, w;
    t = 0;
    while ((awvalid || wvalid) && t < 20) begin
      a = awvalid && awready;
      w = wvalid && wready;
      @(negedge clk);
      if (a) awvalid = 1'b0;
      if (w) wvalid = 1'b0;
      t++;
    end
    check("aw_w_accept", {62'd0, awvalid, wvalid}, 64'd0);
  endtask

  task automatic issue_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb);
    prep_write(addr, data, strb);
    hs_loop();
    check("b_latency", {63'd0, bvalid}, 64'd1);
  endtask

  task automatic wait_b();
    int t;
    logic [1:0] er;
    t = 0;
    while (bvalid !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("bvalid_seen", {63'd0, bvalid}, 64'd1);
    er = bq.pop_front();
    check("bresp", {62'd0, bresp}, {62'd0, er});
    @(negedge clk);
    check("bvalid_drop", {63'd0, bvalid}, 64'd0);
  endtask

  task automatic do_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb);
    issue_write(addr, data, strb);
    wait_b();
  endtask

  task automatic do_read(input logic [5:0] addr);
    int t;
    logic a;
    logic [33:0] e;
    if (addr[5:4] != 2'b00) rq.push_back({32'd0, 2'b10});
    else rq.push_back({model[addr[3:2]], 2'b00});
    araddr = addr; arprot = 3'($urandom_range(7)); arvalid = 1'b1;
    t = 0;
    while (arvalid && t < 20) begin
      a = arready;
      @(negedge clk);
      if (a) arvalid = 1'b0;
      t++;
    end
    check("ar_accept", {63'd0, arvalid}, 64'd0);
    check("r_latency", {63'd0, rvalid}, 64'd1);
    e = rq.pop_front();
    check("rdata", {32'd0, rdata}, {32'd0, e[33:2]});
    check("rresp", {62'd0, rresp}, {62'd0, e[1:0]});
    @(negedge clk);
  endtask

  initial begin
    int p0;
    logic [31:0] old1;
    rst_n = 1'b0; awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0;
    wvalid = 1'b0; bready = 1'b1; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;
    for (int i = 0; i < 4; i++) model[i] = 32'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", {61'd0, awready, wready, arready}, 64'd0);
    check("rst_valid", {61'd0, bvalid, rvalid, reg0_wr_pulse}, 64'd0);
    check("rst_data", {28'd0, rdata, bresp, rresp}, 64'd0);
    rst_n = 1'b1;
    #1 check("ready_before_edge", {61'd0, awready, wready, arready}, 64'd0);
    @(negedge clk);
    check("ready_after_edge", {61'd0, awready, wready, arready}, 64'd7);
    check_regs("rst");

    // Basic write/readback with a single reg0 pulse
    p0 = pulse_cnt;
    do_write(6'h00, 32'h1, 4'hF);
    do_write(6'h04, 32'h2, 4'hF);
    do_write(6'h08, 32'h3, 4'hF);
    do_write(6'h0C, 32'h4, 4'hF);
    for (int i = 0; i < 4; i++) do_read(6'(i * 4));
    check("reg3_const", {32'd0, reg3_o}, 64'h4);
    check("reg0_pulse_count", 64'(pulse_cnt - p0), 64'd1);
    check_regs("basic");

    // W three cycles ahead of AW
    bq.push_back(2'b00);
    model[2] = 32'hA5A5A5A5;
    wdata = 32'hA5A5A5A5; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    check("w_holder_full", {63'd0, wready}, 64'd0);
    repeat (2) begin
      @(negedge clk);
      check("no_b_without_aw", {63'd0, bvalid}, 64'd0);
    end
    awaddr = 6'h08; awvalid = 1'b1;
    check("aw_ready_late", {63'd0, awready}, 64'd1);
    @(negedge clk);
    awvalid = 1'b0;
    check("b_after_aw", {63'd0, bvalid}, 64'd1);
    wait_b();
    check("reg2_const", {32'd0, reg2_o}, 64'hA5A5A5A5);

    // Byte strobes and empty strobe
    do_write(6'h04, 32'hFFFFFFFF, 4'hF);
    do_write(6'h05, 32'h12345678, 4'b0101);
    do_read(6'h04);
    check("reg1_strobe", {32'd0, reg1_o}, 64'hFF34FF78);
    do_write(6'h0C, 32'hDEADBEEF, 4'h0);
    check_regs("strobe");

    // Unmapped addresses
    do_write(6'h10, 32'hCAFEF00D, 4'hF);
    do_read(6'h3C);
    check_regs("unmapped");

    // Back-pressure on B; second write held off until the B handshake
    bready = 1'b0;
    issue_write(6'h00, 32'h55, 4'hF);
    old1 = reg1_o;
    prep_write(6'h04, 32'h66, 4'hF);
    for (int i = 0; i < 10; i++) begin
      check("bp_bvalid", {63'd0, bvalid}, 64'd1);
      check("bp_ready", {62'd0, awready, wready}, 64'd0);
      check("bp_reg1_hold", {32'd0, reg1_o}, {32'd0, old1});
      @(negedge clk);
    end
    bready = 1'b1;
    wait_b();
    hs_loop();
    check("b_latency2", {63'd0, bvalid}, 64'd1);
    wait_b();
    check_regs("bp");

    // Reset while a response is outstanding
    bready = 1'b0;
    issue_write(6'h0C, 32'h77, 4'hF);
    #2 rst_n = 1'b0;
    #1;
    check("rst_bvalid_drop", {63'd0, bvalid}, 64'd0);
    check("rst_ready_low", {61'd0, awready, wready, arready}, 64'd0);
    bq.delete();
    for (int i = 0; i < 4; i++) model[i] = 32'd0;
    check_regs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    bready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("no_b_after_rst", {63'd0, bvalid}, 64'd0);
    end
    for (int i = 0; i < 4; i++) do_read(6'(i * 4));
    check("queues_empty", 64'(bq.size() + rq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
